// File: rtl/vmul16_seq_ctrl.sv
// Sequencer that computes an unsigned 16x16 product by issuing four 8x8 partial
// products to one shared multiplier and accumulating the shifted results.
module vmul16_seq_ctrl #(
    parameter int MUL_PIPE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_p,
    output logic        busy,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [15:0] mul_p
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  step;
    logic        phase;
    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [15:0] pipe_reg;
    logic [31:0] acc;
    logic [31:0] out_p_reg;

    logic [15:0] term;
    logic [31:0] term_shifted;
    logic [31:0] acc_sum;
    logic        acc_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // With the pipe stage, only phase 1 of each step accumulates; phase 0 captures.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        mul_a      = 8'h00;
        mul_b      = 8'h00;
        acc_en     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                mul_a  = step[0] ? a_reg[15:8] : a_reg[7:0];
                mul_b  = step[1] ? b_reg[15:8] : b_reg[7:0];
                acc_en = (MUL_PIPE == 0) || phase;
                if (acc_en && (step == 2'd3)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        term         = (MUL_PIPE != 0) ? pipe_reg : mul_p;
        term_shifted = 32'h0;
        case (step)
            2'd0:    term_shifted = {16'h0000, term};
            2'd1:    term_shifted = {8'h00, term, 8'h00};
            2'd2:    term_shifted = {8'h00, term, 8'h00};
            default: term_shifted = {term, 16'h0000};
        endcase
        acc_sum = acc + term_shifted;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step      <= 2'd0;
            phase     <= 1'b0;
            a_reg     <= 16'h0000;
            b_reg     <= 16'h0000;
            pipe_reg  <= 16'h0000;
            acc       <= 32'h0;
            out_p_reg <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        acc   <= 32'h0;
                        step  <= 2'd0;
                        phase <= 1'b0;
                    end
                end
                RUN: begin
                    if (acc_en) begin
                        acc   <= acc_sum;
                        step  <= step + 2'd1;
                        phase <= 1'b0;
                        if (step == 2'd3) begin
                            out_p_reg <= acc_sum;
                        end
                    end else begin
                        pipe_reg <= mul_p;
                        phase    <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_p = out_p_reg;

endmodule

// File: tb/tb_vmul16_seq_ctrl.sv
// Bench for vmul16_seq_ctrl: one instance per MUL_PIPE setting, each with a real
// 8x8 multiplier, checked every cycle against a transaction-level model.
module tb_vmul16_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [15:0] in_a      [2];
    logic [15:0] in_b      [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] out_p     [2];
    logic        busy      [2];
    logic [7:0]  mul_a     [2];
    logic [7:0]  mul_b     [2];
    logic [15:0] mul_p     [2];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        vmul16_seq_ctrl #(.MUL_PIPE(g)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_a      (in_a[g]),
            .in_b      (in_b[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_p     (out_p[g]),
            .busy      (busy[g]),
            .mul_a     (mul_a[g]),
            .mul_b     (mul_b[g]),
            .mul_p     (mul_p[g])
        );
        assign mul_p[g] = {8'h00, mul_a[g]} * {8'h00, mul_b[g]};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input int d, input string name,
                               input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL dut%0d %s actual=%h required=%h at %0t", d, name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an accepted pair becomes a*b after 4*(1+P) edges
    bit          m_idle    [2] = '{1'b1, 1'b1};
    bit          m_done    [2] = '{1'b0, 1'b0};
    int          m_elapsed [2] = '{0, 0};
    logic [15:0] m_a       [2] = '{16'h0, 16'h0};
    logic [15:0] m_b       [2] = '{16'h0, 16'h0};
    logic [31:0] m_p       [2] = '{32'h0, 32'h0};

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_idle[d]    = 1'b1;
                m_done[d]    = 1'b0;
                m_elapsed[d] = 0;
                m_a[d]       = 16'h0;
                m_b[d]       = 16'h0;
                m_p[d]       = 32'h0;
            end else if (m_idle[d]) begin
                if (in_valid[d]) begin
                    m_idle[d]    = 1'b0;
                    m_a[d]       = in_a[d];
                    m_b[d]       = in_b[d];
                    m_elapsed[d] = 0;
                end
            end else if (!m_done[d]) begin
                m_elapsed[d]++;
                if (m_elapsed[d] == 4 * (d + 1)) begin
                    m_done[d] = 1'b1;
                    m_p[d]    = {16'h0, m_a[d]} * {16'h0, m_b[d]};
                end
            end else if (out_ready[d]) begin
                m_done[d] = 1'b0;
                m_idle[d] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] ea;
        logic [7:0] eb;
        int         st;
        for (int d = 0; d < 2; d++) begin
            ea = 8'h00;
            eb = 8'h00;
            if (!m_idle[d] && !m_done[d]) begin
                st = m_elapsed[d] / (d + 1);
                case (st)
                    0:       begin ea = m_a[d][7:0];  eb = m_b[d][7:0];  end
                    1:       begin ea = m_a[d][15:8]; eb = m_b[d][7:0];  end
                    2:       begin ea = m_a[d][7:0];  eb = m_b[d][15:8]; end
                    default: begin ea = m_a[d][15:8]; eb = m_b[d][15:8]; end
                endcase
            end
            checkOutput(d, "in_ready",  {31'h0, in_ready[d]},  {31'h0, m_idle[d]});
            checkOutput(d, "out_valid", {31'h0, out_valid[d]}, {31'h0, m_done[d]});
            checkOutput(d, "busy",      {31'h0, busy[d]},      {31'h0, !m_idle[d]});
            checkOutput(d, "out_p",     out_p[d],              m_p[d]);
            checkOutput(d, "mul_a",     {24'h0, mul_a[d]},     {24'h0, ea});
            checkOutput(d, "mul_b",     {24'h0, mul_b[d]},     {24'h0, eb});
        end
    end

    // Returns at the negedge right after the accept edge
    task automatic applyStimulus(input int d, input logic [15:0] a, input logic [15:0] b);
        int guard = 0;
        @(negedge clk);
        in_valid[d] = 1'b1;
        in_a[d]     = a;
        in_b[d]     = b;
        while (in_ready[d] !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput(d, "accept_ready", {31'h0, in_ready[d]}, 32'h1);
        @(negedge clk);
        in_valid[d] = 1'b0;
        in_a[d]     = ~a;
        in_b[d]     = ~b;
    endtask

    task automatic waitDone(input int d, output int cnt);
        cnt = 0;
        while (out_valid[d] !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput(d, "done_seen", {31'h0, out_valid[d]}, 32'h1);
    endtask

    task automatic runOp(input int d, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp_p);
        int lat;
        applyStimulus(d, a, b);
        waitDone(d, lat);
        checkOutput(d, "latency", lat, 4 * (d + 1));
        checkOutput(d, "product", out_p[d], exp_p);
        @(negedge clk);
    endtask

    task automatic checkResetOutputs(input int d);
        checkOutput(d, "rst_in_ready",  {31'h0, in_ready[d]},  32'h1);
        checkOutput(d, "rst_out_valid", {31'h0, out_valid[d]}, 32'h0);
        checkOutput(d, "rst_busy",      {31'h0, busy[d]},      32'h0);
        checkOutput(d, "rst_out_p",     out_p[d],              32'h0);
        checkOutput(d, "rst_mul",       {16'h0, mul_a[d], mul_b[d]}, 32'h0);
    endtask

    logic [7:0] seq_a [4] = '{8'hB2, 8'hA1, 8'hB2, 8'hA1};
    logic [7:0] seq_b [4] = '{8'hD4, 8'hD4, 8'hC3, 8'hC3};

    initial begin
        int lat;
        int results;
        int gap;
        logic [15:0] ra;
        logic [15:0] rb;

        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_a[d]      = 16'h0;
            in_b[d]      = 16'h0;
            out_ready[d] = 1'b1;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkResetOutputs(0);
        checkResetOutputs(1);
        #2 rst_n = 1'b1;

        for (int d = 0; d < 2; d++) begin
            $display("[TB] directed tests on MUL_PIPE=%0d", d);
            runOp(d, 16'h1234, 16'h5678, 32'h06260060);
            runOp(d, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
            runOp(d, 16'h0000, 16'hABCD, 32'h00000000);
            runOp(d, 16'h0100, 16'h0100, 32'h00010000);

            applyStimulus(d, 16'hA1B2, 16'hC3D4);
            for (int s = 0; s < 4; s++) begin
                checkOutput(d, "seq_mul_a", {24'h0, mul_a[d]}, {24'h0, seq_a[s]});
                checkOutput(d, "seq_mul_b", {24'h0, mul_b[d]}, {24'h0, seq_b[s]});
                repeat (d + 1) @(negedge clk);
            end
            waitDone(d, lat);
            checkOutput(d, "seq_product", out_p[d], 32'h7BB07D68);
            @(negedge clk);

            applyStimulus(d, 16'h1111, 16'h2222);
            out_ready[d] = 1'b0;
            waitDone(d, lat);
            in_valid[d] = 1'b1;
            in_a[d]     = 16'h3333;
            in_b[d]     = 16'h4444;
            for (int c = 0; c < 5; c++) begin
                checkOutput(d, "bp_valid", {31'h0, out_valid[d]}, 32'h1);
                checkOutput(d, "bp_ready", {31'h0, in_ready[d]},  32'h0);
                checkOutput(d, "bp_p",     out_p[d],              32'h02468642);
                @(negedge clk);
            end
            out_ready[d] = 1'b1;
            @(negedge clk);
            checkOutput(d, "bp_idle_ready", {31'h0, in_ready[d]},  32'h1);
            checkOutput(d, "bp_idle_valid", {31'h0, out_valid[d]}, 32'h0);
            checkOutput(d, "bp_keep_p",     out_p[d],              32'h02468642);
            @(negedge clk);
            in_valid[d] = 1'b0;
            waitDone(d, lat);
            checkOutput(d, "bp_latency", lat, 4 * (d + 1));
            checkOutput(d, "bp_product", out_p[d], 32'h0DA7258C);
            @(negedge clk);

            applyStimulus(d, 16'hBEEF, 16'h1234);
            repeat (2 * (d + 1)) @(negedge clk);
            #3 rst_n = 1'b0;
            #1;
            checkResetOutputs(d);
            @(negedge clk);
            #2 rst_n = 1'b1;
            runOp(d, 16'h00FF, 16'h00FF, 32'h0000FE01);

            results = 0;
            for (int i = 0; i < 1000; i++) begin
                ra  = 16'($urandom);
                rb  = 16'($urandom);
                gap = $urandom_range(0, 3);
                applyStimulus(d, ra, rb);
                if (gap != 0) out_ready[d] = 1'b0;
                waitDone(d, lat);
                repeat (gap) @(negedge clk);
                out_ready[d] = 1'b1;
                checkOutput(d, "rand_product", out_p[d], {16'h0, ra} * {16'h0, rb});
                results++;
                @(negedge clk);
            end
            checkOutput(d, "rand_count", results, 1000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
